// File: rtl/dual_issue_scheduler.sv
// Two-slot in-order issue stage for the dual-pipe SPU core with a per-register countdown scoreboard.
// Define ISSUE_PERF_CNT_EN to add the stall_cnt / dual_cnt performance counter outputs.
module dual_issue_scheduler #(
    parameter int          NUM_REGS = 128,
    parameter logic [0:10] EVEN_NOP = 11'b01000000001,
    parameter logic [0:10] ODD_NOP  = 11'b00000000001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        fetch_valid,
    output logic        fetch_ready,
    input  logic [0:34] fetch_instr0,
    input  logic [0:34] fetch_instr1,
    input  logic [0:31] fetch_pc,
    output logic [0:34] instructionEven,
    output logic [0:34] instructionOdd,
    output logic [0:31] PCout_odd
`ifdef ISSUE_PERF_CNT_EN
    ,
    output logic [0:31] stall_cnt,
    output logic [0:31] dual_cnt
`endif
);

    localparam logic [0:34] EVEN_NOP_WORD = {EVEN_NOP, 24'd0};
    localparam logic [0:34] ODD_NOP_WORD  = {ODD_NOP, 24'd0};

    function automatic logic is_rrr(input logic [0:34] ins);
        case (ins[0:3])
            4'b1100, 4'b1110, 4'b1111: is_rrr = 1'b1;
            default:                   is_rrr = 1'b0;
        endcase
    endfunction

    function automatic logic [6:0] dest_reg(input logic [0:34] ins);
        if (is_rrr(ins)) begin
            dest_reg = ins[4:10];
        end else begin
            dest_reg = ins[25:31];
        end
    endfunction

    function automatic logic [2:0] lat_val(input logic [1:0] code);
        case (code)
            2'b00:   lat_val = 3'd2;
            2'b01:   lat_val = 3'd4;
            2'b10:   lat_val = 3'd6;
            2'b11:   lat_val = 3'd7;
            default: lat_val = 3'd7;
        endcase
    endfunction

    // rc only counts as a source for the RRR forms
    function automatic logic uses_reg(input logic [0:34] ins, input logic [6:0] r);
        uses_reg = (ins[18:24] == r) || (ins[11:17] == r) || (is_rrr(ins) && (ins[25:31] == r));
    endfunction

    function automatic logic srcs_ready(input logic [0:34] ins, input logic [NUM_REGS-1:0] busy);
        logic rc_busy;
        if (is_rrr(ins)) begin
            rc_busy = busy[ins[25:31]];
        end else begin
            rc_busy = 1'b0;
        end
        srcs_ready = !busy[ins[18:24]] && !busy[ins[11:17]] && !rc_busy;
    endfunction

    logic        s0_valid_q, s0_valid_d, s1_valid_q, s1_valid_d;
    logic [0:34] s0_instr_q, s0_instr_d, s1_instr_q, s1_instr_d;
    logic [0:31] s0_pc_q, s0_pc_d, s1_pc_q, s1_pc_d;
    logic [2:0]  cnt_q [NUM_REGS];
    logic [2:0]  cnt_d [NUM_REGS];
    logic [0:34] even_q, even_d, odd_q, odd_d;
    logic [0:31] pc_odd_q, pc_odd_d;

    logic [NUM_REGS-1:0] busy_s;
    logic [0:34] o_instr_s;
    logic        o_valid_s, issue_o_s, dual_s, issue_s0_s, issue_s1_s;
    logic        fetch_ready_s, load_s;
    logic [6:0]  rt0_s, rt1_s;

    // Issue decision: oldest slot first, younger slot only alongside it on the other pipe
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_s[r] = (cnt_q[r] != 3'd0);
        end
        rt0_s      = dest_reg(s0_instr_q);
        rt1_s      = dest_reg(s1_instr_q);
        o_instr_s  = s0_valid_q ? s0_instr_q : s1_instr_q;
        o_valid_s  = s0_valid_q | s1_valid_q;
        issue_o_s  = o_valid_s & srcs_ready(o_instr_s, busy_s) & ~flush;
        dual_s     = s0_valid_q & s1_valid_q & issue_o_s
                   & (s1_instr_q[32] != s0_instr_q[32])
                   & srcs_ready(s1_instr_q, busy_s)
                   & ~uses_reg(s1_instr_q, rt0_s)
                   & (rt1_s != rt0_s);
        issue_s0_s = s0_valid_q & issue_o_s;
        issue_s1_s = (~s0_valid_q & issue_o_s) | dual_s;
        fetch_ready_s = ~flush & (~s0_valid_q | issue_s0_s) & (~s1_valid_q | issue_s1_s);
        load_s     = fetch_valid & fetch_ready_s;
    end

    // Buffer slots: flush beats load, load beats retirement
    always_comb begin
        s0_valid_d = s0_valid_q;
        s1_valid_d = s1_valid_q;
        s0_instr_d = s0_instr_q;
        s1_instr_d = s1_instr_q;
        s0_pc_d    = s0_pc_q;
        s1_pc_d    = s1_pc_q;
        if (flush) begin
            s0_valid_d = 1'b0;
            s1_valid_d = 1'b0;
        end else if (load_s) begin
            s0_valid_d = 1'b1;
            s1_valid_d = 1'b1;
            s0_instr_d = fetch_instr0;
            s1_instr_d = fetch_instr1;
            s0_pc_d    = fetch_pc;
            s1_pc_d    = fetch_pc + 32'd4;
        end else begin
            s0_valid_d = s0_valid_q & ~issue_s0_s;
            s1_valid_d = s1_valid_q & ~issue_s1_s;
        end
    end

    // Scoreboard: issue loads the latency, everything else counts down; flush does not stop it
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (issue_s0_s && (rt0_s == 7'(r))) begin
                cnt_d[r] = lat_val(s0_instr_q[33:34]);
            end else if (issue_s1_s && (rt1_s == 7'(r))) begin
                cnt_d[r] = lat_val(s1_instr_q[33:34]);
            end else if (cnt_q[r] != 3'd0) begin
                cnt_d[r] = cnt_q[r] - 3'd1;
            end else begin
                cnt_d[r] = 3'd0;
            end
        end
    end

    // Pipe steering; a dual issue always targets different pipes
    always_comb begin
        even_d   = EVEN_NOP_WORD;
        odd_d    = ODD_NOP_WORD;
        pc_odd_d = 32'd0;
        case ({issue_s0_s, s0_instr_q[32]})
            2'b10: even_d = s0_instr_q;
            2'b11: begin
                odd_d    = s0_instr_q;
                pc_odd_d = s0_pc_q;
            end
            default: ;
        endcase
        case ({issue_s1_s, s1_instr_q[32]})
            2'b10: even_d = s1_instr_q;
            2'b11: begin
                odd_d    = s1_instr_q;
                pc_odd_d = s1_pc_q;
            end
            default: ;
        endcase
    end

    // State and registered pipe outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            s0_valid_q <= 1'b0;
            s1_valid_q <= 1'b0;
            s0_instr_q <= 35'd0;
            s1_instr_q <= 35'd0;
            s0_pc_q    <= 32'd0;
            s1_pc_q    <= 32'd0;
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= 3'd0;
            end
            even_q     <= EVEN_NOP_WORD;
            odd_q      <= ODD_NOP_WORD;
            pc_odd_q   <= 32'd0;
        end else begin
            s0_valid_q <= s0_valid_d;
            s1_valid_q <= s1_valid_d;
            s0_instr_q <= s0_instr_d;
            s1_instr_q <= s1_instr_d;
            s0_pc_q    <= s0_pc_d;
            s1_pc_q    <= s1_pc_d;
            cnt_q      <= cnt_d;
            even_q     <= even_d;
            odd_q      <= odd_d;
            pc_odd_q   <= pc_odd_d;
        end
    end

    assign fetch_ready     = fetch_ready_s;
    assign instructionEven = even_q;
    assign instructionOdd  = odd_q;
    assign PCout_odd       = pc_odd_q;

`ifdef ISSUE_PERF_CNT_EN
    logic [0:31] stall_cnt_q, stall_cnt_d, dual_cnt_q, dual_cnt_d;
    logic        stall_s;

    // Saturating event counters
    always_comb begin
        stall_s = o_valid_s & ~issue_o_s & ~flush;
        if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (dual_s && (dual_cnt_q != 32'hFFFF_FFFF)) begin
            dual_cnt_d = dual_cnt_q + 32'd1;
        end else begin
            dual_cnt_d = dual_cnt_q;
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
            dual_cnt_q  <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            dual_cnt_q  <= dual_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign dual_cnt  = dual_cnt_q;
`endif

endmodule

// File: doc/dual_issue_scheduler.md
Name: dual_issue_scheduler

Overview:
- Issue stage for the dual-pipe SPU core.
- Accepts an aligned fetched instruction pair and resolves RAW/WAW hazards against in-flight results using a per-register countdown scoreboard.
- Steers each instruction to the even or odd pipe, inserting the pipe-specific NOP wherever nothing issues.
- Drives the instructionEven/instructionOdd/PCin inputs of the processing unit and absorbs branch flushes.

Parameters:
- NUM_REGS, 128: architectural registers; scoreboard depth.
- EVEN_NOP, 11'b01000000001: opcode driven to the even pipe when idle.
- ODD_NOP, 11'b00000000001: opcode driven to the odd pipe when idle.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  branch mispredict; discard buffered instructions.
- fetch_valid  in  1  fetch pair presented.
- fetch_ready  out  1  scheduler can accept the pair this cycle.
- fetch_instr0  in  [0:34]  older instruction of the pair.
- fetch_instr1  in  [0:34]  younger instruction of the pair.
- fetch_pc  in  [0:31]  PC of instr0; the PC of instr1 is fetch_pc+4.
- instructionEven  out  [0:34]  registered even-pipe instruction.
- instructionOdd  out  [0:34]  registered odd-pipe instruction.
- PCout_odd  out  [0:31]  registered PC of the odd-pipe instruction; 0 when NOP.

Behaviour:
Instruction fields:
- [0:31] ISA word.
- [32] pipe select: 0 = even, 1 = odd.
- [33:34] result latency code: 00 = 2, 01 = 4, 10 = 6, 11 = 7 cycles.

Register fields:
- Destination rt is [4:10] when [0:3] is 1100, 1110 or 1111 (RRR forms); otherwise rt is [25:31].
- Sources are always ra [18:24] and rb [11:17]. rc [25:31] is also a source for RRR forms.
- Sources are checked conservatively; false hazards are acceptable.

Buffer:
- Two slots, S0 and S1, each with a valid bit and a PC.
- fetch_ready = (no slot valid) OR (every valid slot issues this cycle).
- When fetch_valid & fetch_ready & !flush, both slots load on the edge.

Scoreboard:
- cnt[r] is a 3-bit counter per register.
- Each cycle every nonzero cnt decrements by 1.
- On issue, cnt[rt] <= latency. The issue load overrides the decrement for that register.
- A source is ready iff cnt[src] == 0.

Issue decision (combinational from the buffer and scoreboard; results registered on the next edge):
- The oldest valid slot, O, issues iff all its sources are ready.
- If O does not issue, nothing issues: stall.
- The younger slot S1 (when O = S0) also issues the same cycle iff all of the following hold:
  - it is valid;
  - its pipe differs from S0's pipe;
  - its sources are ready;
  - no S1 source equals S0.rt;
  - S1.rt != S0.rt.
- Otherwise S1 remains and becomes O next cycle. In-order issue is preserved; S1 never issues before S0.
- Issued slots clear their valid bit.

Outputs:
- Each pipe output receives its issued instruction. An idle pipe gets {NOP opcode, 24'b0}.
- PCout_odd = PC of the issued odd instruction, else 0.
- Latency: a pair accepted at edge E appears on the outputs after edge E+1 at the earliest.

Flush:
- Has priority over fetch load and over issue.
- Clears both slots and drives NOPs on the next edge.
- The scoreboard keeps counting, because older instructions remain in flight.
- fetch_ready = 0 during flush.

Reset:
- Slots invalid and scoreboard all 0.
- instructionEven = {EVEN_NOP, 24'b0}; instructionOdd = {ODD_NOP, 24'b0}; PCout_odd = 0.
- Reset asserted mid-stall discards everything.

Boundary rules:
- Both slots targeting the same pipe: serialise.
- Register 0 is treated as an ordinary register.
- A counter at 1 reaches 0 on the next edge, so the dependent instruction issues one cycle later.

Optional Feature:
Macro ISSUE_PERF_CNT_EN.
- When defined, the block adds outputs stall_cnt [0:31] and dual_cnt [0:31].
  - stall_cnt increments in every cycle where a slot is valid, nothing issues and flush = 0.
  - dual_cnt increments in every cycle where two instructions issue.
  - Both counters clear on reset and saturate at all-ones.
- When not defined, neither port nor its logic exists, and the block's behaviour is otherwise identical.

Test Plan:
1. Reset, then fetch an independent pair: even add rt=5 and odd load rt=6, latency 6. Required response:
   - both issue one cycle after acceptance;
   - PCout_odd = fetch_pc+4;
   - cnt[5] = 2 and cnt[6] = 6.
2. Odd-pipe instruction whose ra = 5 is fetched right after an even instruction with rt=5 and latency 7. Required response:
   - the odd-pipe instruction stalls for exactly 7 cycles, with NOPs on both pipes;
   - then it issues with the correct PC.
3. Pair with both slots on the even pipe. Required response:
   - S0 issues, with an odd NOP on the odd pipe;
   - S1 issues the next cycle;
   - fetch_ready is low in the first cycle and high in the second.
4. Intra-pair RAW (S1.ra = S0.rt = 9, different pipes). Required response: S1 issues exactly 1 cycle after S0 has issued and cnt[9] has drained to 0.
5. Flush asserted while S1 is stalled and fetch_valid = 1. Required response:
   - buffer emptied and the new pair is not loaded;
   - both outputs are NOP on the next edge;
   - a subsequent independent pair issues normally.
6. With ISSUE_PERF_CNT_EN defined, run scenario 2. Required response: stall_cnt = 7 and dual_cnt = 0. Then run scenario 1 again: dual_cnt = 1.
